i2c_slave_regfile: RTL and testbench
====================================

Name: i2c_slave_regfile

Overview:
- I2C target (slave) that consumes the bus traffic produced by the I2C master. In simulation it sits directly on the master's i2c_sda/i2c_scl wires.
- Decodes START/STOP, matches a 7-bit device address, and ACKs.
- Serves a small register file with an auto-incrementing pointer: writes set the pointer and then registers; reads return registers.
- A local sideband port exposes register contents and write events to the system.

Parameters:
- DEV_ADDR, 7'h50, 7-bit target address.
- NUM_REGS, 16, number of 8-bit registers; power of 2, range 2..256.
- RESET_VAL, 8'h00, reset value of every register.

Ports:
- clk  input  1  system clock; SCL high and low phases each last at least 8 clk periods.
- reset  input  1  asynchronous, active-low reset.
- i2c_scl  input  1  bus clock; the block never stretches it.
- i2c_sda  inout  1  open-drain data line; driven 1'b0 or 1'bz only.
- rd_addr  input  log2(NUM_REGS)  sideband register select.
- rd_data  output  8  combinational value of regfile[rd_addr].
- wr_strobe  output  1  one-cycle pulse when a bus write commits a register.
- wr_addr  output  log2(NUM_REGS)  register index of the last bus write.
- wr_data  output  8  data of the last bus write.
- busy  output  1  high from START until STOP.

Behaviour:
- Reset (reset=0) immediately and asynchronously:
  - i2c_sda released to z.
  - State = IDLE; pointer = 0; every register = RESET_VAL.
  - wr_strobe=0, wr_addr=0, wr_data=0, busy=0.
- Input sync: SCL and SDA each pass through 2 flops. Edges are detected by comparing with a 3rd flop; all decoding uses the synced signals.
- Bus conditions:
  - START: synced SDA 1->0 while synced SCL=1.
  - STOP: synced SDA 0->1 while SCL=1.
  - START or repeated START in any state: go to ADDR, bit counter=0, busy=1, SDA released.
  - STOP in any state: go to IDLE, SDA released, busy=0. Any partial byte is discarded and never written.
- Timing: data is sampled on synced SCL rising edge. SDA drive changes on the clk after a synced SCL falling edge is detected, so it is always stable while SCL is high.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits, MSB first. If bits[7:1]==DEV_ADDR go to ACK_ADDR; otherwise go to IGNORE and drive nothing.
  - ACK_ADDR: drive 0 for one SCL period. Then go to RDATA if R/W=1, else PTR.
  - PTR: shift 8 bits, pointer = byte mod NUM_REGS, then ACK_PTR (drive 0), then WDATA.
  - WDATA: shift 8 bits; on the 8th SCL rising edge:
    - regfile[pointer] <= byte;
    - wr_strobe=1 for exactly one clk;
    - wr_addr = pointer, wr_data = byte;
    - pointer increments mod NUM_REGS.
    - Then ACK_W (drive 0), then back to WDATA.
  - RDATA:
    - Load regfile[pointer] at the start of the byte and drive its bits MSB first (0 -> drive low, 1 -> z).
    - Pointer increments mod NUM_REGS after the byte's 8th bit.
    - Then MACK: release SDA and sample the master's bit. 0 = ACK, go to RDATA for the next byte. 1 = NACK, go to IGNORE.
  - IGNORE: SDA released; wait for STOP or START.
- Pointer wrap: NUM_REGS-1 +1 -> 0, for both reads and writes.
- Pointer persistence: the pointer persists across transactions. A read with no preceding pointer write starts from the last pointer value.
- Bus collision: if the block drives SDA=1 (z) in RDATA but samples 0, it goes to IGNORE; the master's arbitration wins.
- Sideband write ordering: a bus write and a sideband read of the same index in the same clk return the old value on rd_data. The new value appears the next clk.
- Sizing: only the low log2(NUM_REGS) bits of the pointer byte are used.

Test Plan:
- Reset: hold reset=0 for 5 clk mid-byte -> i2c_sda=z at once; all registers read 8'h00 via rd_addr; busy=0.
- Write: START, 0xA0, 0x03, 0x5A, 0xC3, STOP -> ACK on all 4 bytes; wr_strobe pulses twice with (3,0x5A) then (4,0xC3); rd_data at rd_addr=3 is 0x5A, at rd_addr=4 is 0xC3.
- Random read: START, 0xA0, 0x03, repeated START, 0xA1, master ACK then NACK, STOP -> bytes 0x5A and 0xC3 returned; SDA released after NACK; pointer ends at 5.
- Address mismatch: START, 0xA2, 0x11, STOP -> no ACK (SDA stays z throughout); no wr_strobe; registers unchanged.
- Wrap: write pointer 0x0F, then data 0x11, 0x22 -> reg15=0x11, reg0=0x22.
- Abort: STOP after 4 data bits of a write -> no register change; busy=0; next START with 0xA0 is ACKed.

Source files
------------

// File: rtl/i2c_slave_regfile.sv
// I2C target: address match, auto-incrementing register pointer, and a sideband
// port for local register reads and write notifications.
module i2c_slave_regfile #(
   parameter logic [6:0] DEV_ADDR  = 7'h50,
   parameter int         NUM_REGS  = 16,
   parameter logic [7:0] RESET_VAL = 8'h00,
   localparam int        AW        = $clog2(NUM_REGS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i2c_scl,
   inout  wire           i2c_sda,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   output logic          wr_strobe,
   output logic [AW-1:0] wr_addr,
   output logic [7:0]    wr_data,
   output logic          busy
);
   typedef enum logic [3:0] {
      IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WDATA, ACK_W, RDATA, MACK, IGNORE
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    scl_sync_q, sda_sync_q;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [6:0]    shift_q, shift_d;
   logic [7:0]    tx_q, tx_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic          rw_q, rw_d;
   logic          sda_oe_q, sda_oe_d;
   logic          busy_q, busy_d;
   logic          wr_strobe_q, wr_strobe_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]    wr_data_q, wr_data_d;
   logic [7:0]    regs_q [NUM_REGS];
   logic          reg_we;
   logic [7:0]    rx_byte, cur_reg;
   logic          scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

   // Bit [1] is the synchronised level, bit [2] its previous value for edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_sync_q <= 3'b111;
         sda_sync_q <= 3'b111;
      end else begin
         scl_sync_q <= {scl_sync_q[1:0], i2c_scl};
         sda_sync_q <= {sda_sync_q[1:0], i2c_sda};
      end
   end

   assign scl_s     = scl_sync_q[1];
   assign sda_s     = sda_sync_q[1];
   assign scl_rise  = scl_s & ~scl_sync_q[2];
   assign scl_fall  = ~scl_s & scl_sync_q[2];
   assign start_det = scl_s & scl_sync_q[2] & sda_sync_q[2] & ~sda_s;
   assign stop_det  = scl_s & scl_sync_q[2] & ~sda_sync_q[2] & sda_s;
   assign rx_byte   = {shift_q, sda_s};
   assign cur_reg   = regs_q[ptr_q];

   assign i2c_sda   = sda_oe_q ? 1'b0 : 1'bz;
   assign rd_data   = regs_q[rd_addr];
   assign wr_strobe = wr_strobe_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign busy      = busy_q;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      tx_d        = tx_q;
      ptr_d       = ptr_q;
      rw_d        = rw_q;
      sda_oe_d    = sda_oe_q;
      busy_d      = busy_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      reg_we      = 1'b0;
      if (start_det) begin
         state_d   = ADDR;
         bit_cnt_d = 4'd0;
         busy_d    = 1'b1;
         sda_oe_d  = 1'b0;
      end else if (stop_det) begin
         state_d   = IDLE;
         bit_cnt_d = 4'd0;
         busy_d    = 1'b0;
         sda_oe_d  = 1'b0;
      end else begin
         case (state_q)
            ADDR, PTR, WDATA: if (scl_rise) begin
               shift_d   = rx_byte[6:0];
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd7) begin
                  bit_cnt_d = 4'd0;
                  case (state_q)
                     ADDR: begin
                        if (rx_byte[7:1] == DEV_ADDR) begin
                           rw_d    = rx_byte[0];
                           state_d = ACK_ADDR;
                        end else begin
                           state_d = IGNORE;
                        end
                     end
                     PTR: begin
                        ptr_d   = rx_byte[AW-1:0];
                        state_d = ACK_PTR;
                     end
                     default: begin
                        reg_we      = 1'b1;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = ptr_q;
                        wr_data_d   = rx_byte;
                        ptr_d       = ptr_q + AW'(1);
                        state_d     = ACK_W;
                     end
                  endcase
               end
            end
            // First falling edge starts the ACK pulse, the second one ends it.
            ACK_ADDR, ACK_PTR, ACK_W: if (scl_fall) begin
               if (bit_cnt_q == 4'd0) begin
                  sda_oe_d  = 1'b1;
                  bit_cnt_d = 4'd1;
               end else begin
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = 4'd0;
                  if (state_q == ACK_ADDR && rw_q) begin
                     tx_d     = cur_reg;
                     sda_oe_d = ~cur_reg[7];
                     state_d  = RDATA;
                  end else if (state_q == ACK_ADDR) begin
                     state_d = PTR;
                  end else begin
                     state_d = WDATA;
                  end
               end
            end
            RDATA: begin
               if (scl_rise) begin
                  if (!sda_oe_q && !sda_s) begin
                     state_d = IGNORE;
                  end else begin
                     tx_d      = {tx_q[6:0], 1'b0};
                     bit_cnt_d = bit_cnt_q + 4'd1;
                     if (bit_cnt_q == 4'd7) ptr_d = ptr_q + AW'(1);
                  end
               end else if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = 4'd0;
                     state_d   = MACK;
                  end else begin
                     sda_oe_d = ~tx_q[7];
                  end
               end
            end
            // bit_cnt doubles as "master acknowledged" until the next falling edge.
            MACK: begin
               if (scl_rise) begin
                  if (sda_s) state_d = IGNORE;
                  else bit_cnt_d = 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd1) begin
                  tx_d      = cur_reg;
                  sda_oe_d  = ~cur_reg[7];
                  bit_cnt_d = 4'd0;
                  state_d   = RDATA;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         bit_cnt_q   <= 4'd0;
         shift_q     <= 7'd0;
         tx_q        <= 8'd0;
         ptr_q       <= '0;
         rw_q        <= 1'b0;
         sda_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= 8'd0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         tx_q        <= tx_d;
         ptr_q       <= ptr_d;
         rw_q        <= rw_d;
         sda_oe_q    <= sda_oe_d;
         busy_q      <= busy_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
      end else if (reg_we) begin
         regs_q[ptr_q] <= rx_byte;
      end
   end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bit-banged I2C master driving i2c_slave_regfile; a register-array model predicts
// write strobes and read data, and a monitor checks every wr_strobe against a queue.
module tb_i2c_slave_regfile;
   localparam int NREG = 16;

   typedef struct {
      logic [3:0] a;
      logic [7:0] d;
   } wr_t;

   logic       clk;
   logic       rst_n;
   logic       scl_m;
   logic       m_low;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic       wr_strobe;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;
   wire        sda;

   assign sda = m_low ? 1'b0 : 1'bz;
   pullup (sda);

   i2c_slave_regfile #(.DEV_ADDR(7'h50), .NUM_REGS(NREG), .RESET_VAL(8'h00)) dut (
      .clk       (clk),
      .reset     (rst_n),
      .i2c_scl   (scl_m),
      .i2c_sda   (sda),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] model_regs [NREG];
   int         model_ptr;
   wr_t        exp_wr [$];
   logic [7:0] exp_rd [$];
   logic [7:0] wbuf [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every strobe must match the oldest predicted write.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (rst_n && wr_strobe) begin
            if (exp_wr.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL wr_strobe_unexpected: got addr %0h data %0h, expected no write", wr_addr, wr_data);
            end else begin
               e = exp_wr.pop_front();
               check("wr_addr", 32'(wr_addr), 32'(e.a));
               check("wr_data", 32'(wr_data), 32'(e.d));
               $display("[TB] wr_strobe addr=%0d data=%02h", wr_addr, wr_data);
            end
         end
      end
   end

   task automatic clk_wait(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_xfer(input logic b, output logic r);
      clk_wait(6); m_low = ~b;
      clk_wait(6); scl_m = 1'b1;
      clk_wait(6); r = sda;
      clk_wait(6); scl_m = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
      bit_xfer(1'b1, r);
      ack = ~r;
   endtask

   task automatic read_byte(input logic do_ack, output logic [7:0] b);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, r);
         b[i] = r;
      end
      bit_xfer(~do_ack, r);
   endtask

   task automatic do_start();
      clk_wait(6); m_low = 1'b1;
      clk_wait(6); scl_m = 1'b0;
   endtask

   task automatic do_rstart();
      clk_wait(6); m_low = 1'b0;
      clk_wait(6); scl_m = 1'b1;
      clk_wait(6); m_low = 1'b1;
      clk_wait(6); scl_m = 1'b0;
   endtask

   task automatic do_stop();
      clk_wait(6); m_low = 1'b1;
      clk_wait(6); scl_m = 1'b1;
      clk_wait(6); m_low = 1'b0;
      clk_wait(6);
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < NREG; i++) begin
         rd_addr = 4'(i);
         #1;
         check($sformatf("%s_reg%0d", tag, i), 32'(rd_data), 32'(model_regs[i]));
      end
   endtask

   task automatic bus_write(input logic [6:0] dev, input logic [7:0] ptr, input int n);
      logic a;
      logic match;
      wr_t  e;
      match = (dev == 7'h50);
      do_start();
      check("busy_after_start", 32'(busy), 32'd1);
      write_byte({dev, 1'b0}, a);
      check("ack_waddr", 32'(a), 32'(match));
      write_byte(ptr, a);
      check("ack_ptr", 32'(a), 32'(match));
      if (match) model_ptr = ptr % NREG;
      for (int i = 0; i < n; i++) begin
         if (match) begin
            e.a = 4'(model_ptr);
            e.d = wbuf[i];
            exp_wr.push_back(e);
            model_regs[model_ptr] = wbuf[i];
            model_ptr = (model_ptr + 1) % NREG;
         end
         write_byte(wbuf[i], a);
         check("ack_wdata", 32'(a), 32'(match));
      end
      do_stop();
      check("busy_after_stop", 32'(busy), 32'd0);
      $display("[TB] write dev=%02h ptr=%02h bytes=%0d", dev, ptr, n);
      check_regs("wr");
   endtask

   task automatic bus_read(input logic [6:0] dev, input logic set_ptr, input logic [7:0] ptr, input int n);
      logic       a;
      logic       match;
      logic [7:0] b;
      logic [7:0] e;
      match = (dev == 7'h50);
      do_start();
      if (set_ptr) begin
         write_byte({dev, 1'b0}, a);
         check("ack_waddr", 32'(a), 32'(match));
         write_byte(ptr, a);
         check("ack_ptr", 32'(a), 32'(match));
         if (match) model_ptr = ptr % NREG;
         do_rstart();
      end
      write_byte({dev, 1'b1}, a);
      check("ack_raddr", 32'(a), 32'(match));
      if (match) begin
         for (int i = 0; i < n; i++) begin
            exp_rd.push_back(model_regs[model_ptr]);
            model_ptr = (model_ptr + 1) % NREG;
            read_byte(i != n - 1, b);
            e = exp_rd.pop_front();
            check("rd_byte", 32'(b), 32'(e));
            $display("[TB] read byte %0d = %02h", i, b);
         end
         clk_wait(8);
         check("sda_released_after_nack", 32'(sda), 32'd1);
      end
      do_stop();
      check("busy_after_stop", 32'(busy), 32'd0);
      $display("[TB] read dev=%02h set_ptr=%0b bytes=%0d", dev, set_ptr, n);
   endtask

   initial begin
      logic       a;
      logic       r;
      logic [7:0] addr_byte;
      logic [6:0] dev;
      int         kind;
      int         n;

      rst_n = 1'b0; scl_m = 1'b1; m_low = 1'b0; rd_addr = 4'd0;
      for (int i = 0; i < NREG; i++) model_regs[i] = 8'h00;
      model_ptr = 0;

      clk_wait(3); #1;
      check("rst_sda", 32'(sda), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check_regs("rst");
      rst_n = 1'b1;
      clk_wait(5);

      // Populate a register so the following reset has something to clear.
      wbuf[0] = 8'h77;
      bus_write(7'h50, 8'h09, 1);

      // Reset while the target is driving its address ACK.
      do_start();
      addr_byte = 8'hA0;
      for (int i = 7; i >= 0; i--) bit_xfer(addr_byte[i], r);
      m_low = 1'b0;
      clk_wait(6);
      check("ack_driven_before_reset", 32'(sda), 32'd0);
      rst_n = 1'b0;
      #1;
      check("sda_async_release", 32'(sda), 32'd1);
      clk_wait(5);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_wr_addr", 32'(wr_addr), 32'd0);
      check("midrst_wr_data", 32'(wr_data), 32'd0);
      for (int i = 0; i < NREG; i++) model_regs[i] = 8'h00;
      model_ptr = 0;
      check_regs("midrst");
      rst_n = 1'b1;
      clk_wait(2);
      scl_m = 1'b1;
      clk_wait(12);
      $display("[TB] mid-transfer reset done");

      wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
      bus_write(7'h50, 8'h03, 2);
      bus_read(7'h50, 1'b1, 8'h03, 2);
      bus_read(7'h50, 1'b0, 8'h00, 1);

      bus_write(7'h51, 8'h11, 0);

      wbuf[0] = 8'h11; wbuf[1] = 8'h22;
      bus_write(7'h50, 8'h0F, 2);
      bus_read(7'h50, 1'b1, 8'h0F, 3);

      // Abort a write after four data bits.
      do_start();
      write_byte(8'hA0, a);
      check("abort_ack_addr", 32'(a), 32'd1);
      write_byte(8'h07, a);
      check("abort_ack_ptr", 32'(a), 32'd1);
      model_ptr = 7;
      bit_xfer(1'b1, r); bit_xfer(1'b0, r); bit_xfer(1'b1, r); bit_xfer(1'b0, r);
      do_stop();
      check("abort_busy", 32'(busy), 32'd0);
      check_regs("abort");
      do_start();
      write_byte(8'hA0, a);
      check("after_abort_ack", 32'(a), 32'd1);
      do_stop();
      $display("[TB] abort sequence done");

      for (int t = 0; t < 20; t++) begin
         kind = int'($urandom_range(0, 3));
         n    = int'($urandom_range(1, 4));
         case (kind)
            0: begin
               for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
               bus_write(7'h50, 8'($urandom), n);
            end
            1: bus_read(7'h50, 1'b1, 8'($urandom), n);
            2: bus_read(7'h50, 1'b0, 8'h00, n);
            default: begin
               dev = 7'($urandom);
               if (dev == 7'h50) dev = 7'h51;
               if ($urandom_range(0, 1) == 1) begin
                  bus_read(dev, 1'b0, 8'h00, n);
               end else begin
                  for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
                  bus_write(dev, 8'($urandom), n);
               end
            end
         endcase
      end

      clk_wait(20);
      check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
      check_regs("final");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
